// File: rtl/io_key_scan_pkg.sv
// Shared constants, scan FSM state type and key-index helper for the 5x5 key matrix scanner.
package io_key_scan_pkg;

  localparam int NUM_ROW = 5;
  localparam int NUM_COL = 5;
  localparam int NUM_KEY = 25;
  localparam int KEY_W   = 5;
  localparam int EV_W    = 6;
  localparam int IDX_W   = 3;

  typedef enum logic {
    DWELL = 1'b0,
    PROC  = 1'b1
  } scan_state_e;

  // Column-major key numbering: all rows of column 0 first, then column 1, ...
  function automatic logic [KEY_W-1:0] key_index(input logic [IDX_W-1:0] col,
                                                 input logic [IDX_W-1:0] row);
    return KEY_W'(col) * KEY_W'(NUM_ROW) + KEY_W'(row);
  endfunction

endpackage

// File: rtl/io_ev_fifo.sv
// First-word-fall-through event queue; the head entry is visible combinationally while non-empty.
module io_ev_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_key_scan.sv
// 5x5 key matrix scanner: column drive, row synchronizer, per-key debounce and a queued press/release event stream.
module io_key_scan
  import io_key_scan_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CNT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_ROW-1:0] btny,
  output logic [NUM_COL-1:0] btnx,
  output logic [NUM_KEY-1:0] btn,
  output logic               ev_valid,
  output logic [EV_W-1:0]    ev_data,
  input  logic               ev_ready,
  output logic               ev_overflow,
  input  logic               ovf_clr
);

  localparam int CW = $clog2(FIFO_DEPTH);

  logic [NUM_ROW-1:0] r_sync1;
  logic [NUM_ROW-1:0] r_sync2;
  logic [NUM_ROW-1:0] r_raw;

  scan_state_e        r_state;
  scan_state_e        w_state_next;
  logic [IDX_W-1:0]   r_col;
  logic [IDX_W-1:0]   w_col_next;
  logic [IDX_W-1:0]   r_row;
  logic [IDX_W-1:0]   w_row_next;
  logic [15:0]        r_dwell;
  logic [15:0]        w_dwell_next;

  logic               w_last_dwell;
  logic               w_proc;
  logic [KEY_W-1:0]   w_key;
  logic               w_raw_bit;
  logic [NUM_KEY-1:0] w_tog_vec;
  logic               w_push;
  logic [EV_W-1:0]    w_ev;

  logic               w_full;
  logic               w_empty;
  logic [CW:0]        w_count;
  logic               w_pop_eff;
  logic               w_drop;
  logic               r_ovf;

  // Rows idle high, so the synchronizer resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btny;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DWELL;
      r_col   <= '0;
      r_row   <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_dwell <= w_dwell_next;
    end
  end

  assign w_last_dwell = (r_state == DWELL) && (r_dwell == 16'(SCAN_DIV - 1));

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_dwell_next = r_dwell;
    case (r_state)
      DWELL: begin
        if (w_last_dwell) begin
          w_state_next = PROC;
          w_row_next   = '0;
          w_dwell_next = '0;
        end else begin
          w_dwell_next = r_dwell + 16'd1;
        end
      end
      PROC: begin
        if (r_row == IDX_W'(NUM_ROW - 1)) begin
          w_state_next = DWELL;
          w_row_next   = '0;
          w_dwell_next = '0;
          w_col_next   = (r_col == IDX_W'(NUM_COL - 1)) ? '0 : r_col + IDX_W'(1);
        end else begin
          w_row_next = r_row + IDX_W'(1);
        end
      end
      default: begin
        w_state_next = DWELL;
      end
    endcase
  end

  // btnx keeps the current column selected through PROC, so it depends only on r_col.
  always_comb begin
    btnx   = ~(NUM_COL'(1) << r_col);
    w_proc = (r_state == PROC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw <= '0;
    end else if (w_last_dwell) begin
      r_raw <= ~r_sync2;
    end
  end

  assign w_key     = key_index(r_col, r_row);
  assign w_raw_bit = r_raw[r_row];

  for (genvar gi = 0; gi < NUM_KEY; gi++) begin : g_key
    logic [2:0] r_deb;
    logic       r_btn_k;
    logic       w_sel;
    logic       w_diff;
    logic [2:0] w_inc;

    assign w_sel         = w_proc && (w_key == KEY_W'(gi));
    assign w_diff        = (w_raw_bit != r_btn_k);
    assign w_inc         = r_deb + 3'd1;
    assign w_tog_vec[gi] = w_sel && w_diff && (w_inc == 3'(DEB_CNT));
    assign btn[gi]       = r_btn_k;

    // The key still toggles even when its event is dropped by a full queue.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_deb   <= '0;
        r_btn_k <= 1'b0;
      end else if (w_sel) begin
        if (!w_diff) begin
          r_deb <= '0;
        end else if (w_tog_vec[gi]) begin
          r_deb   <= '0;
          r_btn_k <= ~r_btn_k;
        end else begin
          r_deb <= w_inc;
        end
      end
    end
  end

  assign w_push = |w_tog_vec;
  assign w_ev   = {w_raw_bit, w_key};

  io_ev_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_ev),
    .o_full  (w_full),
    .i_pop   (ev_ready),
    .o_data  (ev_data),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign ev_valid  = (w_count != '0);
  assign w_pop_eff = ev_ready && !w_empty;
  assign w_drop    = w_push && w_full && !w_pop_eff;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ev_overflow = r_ovf;

endmodule

// File: tb/tb_io_key_scan.sv
// Self-checking bench for io_key_scan: matrix model driving btny plus a scan-level debounce/event reference.
module tb_io_key_scan;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_CNT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int SCAN_LEN   = 5 * (SCAN_DIV + 5);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btny;
  logic [4:0]  btnx;
  logic [24:0] btn;
  logic        ev_valid;
  logic [5:0]  ev_data;
  logic        ev_ready = 1'b0;
  logic        ev_overflow;
  logic        ovf_clr = 1'b0;

  logic [24:0] pressed = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [5:0]  obs_q[$];
  int          obs_cyc_q[$];
  logic [5:0]  exp_q[$];
  logic [24:0] btn_obs_q[$];
  logic [24:0] btn_exp_q[$];
  logic [24:0] m_btn;
  int          m_cnt[25];

  io_key_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_CNT    (DEB_CNT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btny        (btny),
    .btnx        (btnx),
    .btn         (btn),
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .ev_ready    (ev_ready),
    .ev_overflow (ev_overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    btny = 5'h1F;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++)
        if (!btnx[c] && pressed[c*5+r]) btny[r] = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ev_ready = 1'b0;
    ovf_clr = 1'b0;
    pressed = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
    btn_obs_q.delete();
    btn_exp_q.delete();
    m_btn = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  // One scan samples every key once, column by column, ascending row.
  task automatic model_scan(input logic [24:0] p);
    for (int k = 0; k < 25; k++) begin
      if (p[k] == m_btn[k]) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == DEB_CNT) begin
          m_btn[k] = ~m_btn[k];
          m_cnt[k] = 0;
          exp_q.push_back({p[k], 5'(k)});
        end
      end
    end
  endtask

  task automatic record_pop();
    if (ev_valid && ev_ready) begin
      obs_q.push_back(ev_data);
      obs_cyc_q.push_back(cyc);
      $display("event cycle=%0d data=%b", cyc, ev_data);
    end
  endtask

  // mode 0: ev_ready low, 1: ev_ready high, 2: random ev_ready
  task automatic run_scans(input int n, input int mode, input logic [24:0] p);
    for (int s = 0; s < n; s++) begin
      pressed = p;
      btn_obs_q.push_back(btn);
      btn_exp_q.push_back(m_btn);
      model_scan(p);
      for (int i = 0; i < SCAN_LEN; i++) begin
        ev_ready = (mode == 1) || (mode == 2 && $urandom_range(0, 3) != 0);
        record_pop();
        step();
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      ev_ready = 1'b1;
      record_pop();
      step();
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (btnx !== 5'b11110) begin n_bad++; $display("FAIL reset_btnx: got %b expected %b", btnx, 5'b11110); end
    n_cmp++; if (btn !== 25'h0) begin n_bad++; $display("FAIL reset_btn: got %h expected 0", btn); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ev_valid: got %b expected 0", ev_valid); end
    n_cmp++; if (ev_data !== 6'h0) begin n_bad++; $display("FAIL reset_ev_data: got %b expected 0", ev_data); end
    n_cmp++; if (ev_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", ev_overflow); end
    do_reset();
    for (int i = 0; i < SCAN_LEN; i++) begin
      e = ~(5'd1 << (i / (SCAN_DIV + 5)));
      n_cmp++; if (btnx !== e) begin n_bad++; $display("FAIL idle_btnx cycle %0d: got %b expected %b", i, btnx, e); end
      n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL idle_ev_valid cycle %0d: got %b expected 0", i, ev_valid); end
      step();
    end
    run_scans(4, 1, 25'h0);
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL idle_events: got %0d expected 0", obs_q.size()); end
    n_cmp++; if (btn !== 25'h0) begin n_bad++; $display("FAIL idle_btn: got %h expected 0", btn); end
  endtask

  task automatic test_hold();
    do_reset();
    run_scans(6, 1, 25'h1 << 7);
    drain(4);
    n_cmp++; if (btn_obs_q[1] !== 25'h0) begin n_bad++; $display("FAIL hold_btn_scan1: got %h expected 0", btn_obs_q[1]); end
    n_cmp++; if (btn_obs_q[2] !== 25'h80) begin n_bad++; $display("FAIL hold_btn_scan2: got %h expected %h", btn_obs_q[2], 25'h80); end
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL hold_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_cmp++; if (obs_q[0] !== 6'b100111) begin n_bad++; $display("FAIL hold_event: got %b expected %b", obs_q[0], 6'b100111); end
      n_cmp++; if (obs_cyc_q[0] != 61) begin n_bad++; $display("FAIL hold_latency: got cycle %0d expected 61", obs_cyc_q[0]); end
    end
    n_cmp++; if (btn !== m_btn) begin n_bad++; $display("FAIL hold_btn_final: got %h expected %h", btn, m_btn); end
  endtask

  task automatic test_glitch();
    do_reset();
    run_scans(1, 1, 25'h1 << 7);
    run_scans(3, 1, 25'h0);
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL glitch_events: got %0d expected 0", obs_q.size()); end
    n_cmp++; if (btn !== 25'h0) begin n_bad++; $display("FAIL glitch_btn: got %h expected 0", btn); end
    run_scans(3, 1, 25'h1 << 7);
    run_scans(3, 1, 25'h0);
    drain(4);
    n_cmp++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL release_count: got %0d expected 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_cmp++; if (obs_q[0] !== 6'b100111) begin n_bad++; $display("FAIL release_press: got %b expected %b", obs_q[0], 6'b100111); end
      n_cmp++; if (obs_q[1] !== 6'b000111) begin n_bad++; $display("FAIL release_event: got %b expected %b", obs_q[1], 6'b000111); end
    end
    n_cmp++; if (btn !== 25'h0) begin n_bad++; $display("FAIL release_btn: got %h expected 0", btn); end
  endtask

  task automatic test_multi();
    logic [5:0] e [3];
    e[0] = 6'b100101; e[1] = 6'b100110; e[2] = 6'b101001;
    do_reset();
    run_scans(2, 0, (25'h1 << 5) | (25'h1 << 6) | (25'h1 << 9));
    n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL multi_valid: got %b expected 1", ev_valid); end
    n_cmp++; if (ev_data !== e[0]) begin n_bad++; $display("FAIL multi_head_stable: got %b expected %b", ev_data, e[0]); end
    drain(6);
    n_cmp++; if (obs_q.size() != 3) begin n_bad++; $display("FAIL multi_count: got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== e[i]) begin n_bad++; $display("FAIL multi_order[%0d]: got %b expected %b", i, obs_q[i], e[i]); end
    end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL multi_empty: got %b expected 0", ev_valid); end
  endtask

  task automatic test_overflow();
    logic [5:0] e [4];
    e[0] = 6'b100101; e[1] = 6'b100110; e[2] = 6'b100111; e[3] = 6'b101000;
    do_reset();
    run_scans(2, 0, 25'h1F << 5);
    n_cmp++; if (ev_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", ev_overflow); end
    n_cmp++; if (btn !== (25'h1F << 5)) begin n_bad++; $display("FAIL ovf_btn: got %h expected %h", btn, 25'h1F << 5); end
    drain(6);
    n_cmp++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL ovf_count: got %0d expected 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== e[i]) begin n_bad++; $display("FAIL ovf_entry[%0d]: got %b expected %b", i, obs_q[i], e[i]); end
    end
    n_cmp++; if (ev_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", ev_overflow); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_cmp++; if (ev_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b expected 0", ev_overflow); end
  endtask

  task automatic test_reset_mid_proc();
    do_reset();
    run_scans(1, 0, (25'h1 << 5) | (25'h1 << 6));
    for (int i = 0; i < 15; i++) step();
    n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b expected 1", ev_valid); end
    n_cmp++; if (btn[6:5] !== 2'b11) begin n_bad++; $display("FAIL mid_pre_btn: got %b expected 11", btn[6:5]); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_valid: got %b expected 0", ev_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b expected 0", ev_valid); end
    n_cmp++; if (btn !== 25'h0) begin n_bad++; $display("FAIL mid_btn: got %h expected 0", btn); end
    n_cmp++; if (btnx !== 5'b11110) begin n_bad++; $display("FAIL mid_btnx: got %b expected %b", btnx, 5'b11110); end
    do_reset();
    n_cmp++; if (btnx !== 5'b11110) begin n_bad++; $display("FAIL mid_restart_col: got %b expected %b", btnx, 5'b11110); end
    run_scans(2, 1, 25'h0);
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL mid_no_events: got %0d expected 0", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [24:0] p;
    do_reset();
    p = '0;
    for (int s = 0; s < 30; s++) begin
      p = p ^ (25'h1 << $urandom_range(0, 24));
      if ($urandom_range(0, 1) == 1) p = p ^ (25'h1 << $urandom_range(0, 24));
      run_scans(1, 2, p);
    end
    run_scans(3, 1, p);
    drain(4);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_event[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < btn_obs_q.size(); i++) begin
      n_cmp++; if (btn_obs_q[i] !== btn_exp_q[i]) begin n_bad++; $display("FAIL rand_btn[%0d]: got %h expected %h", i, btn_obs_q[i], btn_exp_q[i]); end
    end
    n_cmp++; if (ev_overflow !== 1'b0) begin n_bad++; $display("FAIL rand_ovf: got %b expected 0", ev_overflow); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_glitch();
    test_multi();
    test_overflow();
    test_reset_mid_proc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
